// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential signed multiplier: default widths and FSM encoding.
// Optional early exit is controlled by SEQ_MULT_EARLY_EXIT_EN in seq_signed_mult_core.
package seq_mult_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult_step_ctr.sv
// Mod-W step counter with enable, synchronous clear and terminal-count output.
module seq_mult_step_ctr
    import seq_mult_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    assign tc = en && (count == LAST);

    // Clear wins over enable so an early exit lands on step 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_signed_mult_core.sv
// Shift-add signed multiplier: magnitudes are multiplied one bit per clock, sign applied in FIN.
// Define SEQ_MULT_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier bits are zero.
module seq_signed_mult_core
    import seq_mult_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    multiplicand,
    input  logic [W-1:0]    multiplier,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  product,
    output logic [CW-1:0]   step
);

    // Handshake: start is a request taken only while busy==0 (otherwise dropped, not queued);
    // done is a one-cycle valid with no ready, product stays put until the next accepted start.

    state_t         state, state_nxt;
    logic [W-1:0]   mcand_mag, mplier_mag, mplier_nxt;
    logic           neg;
    logic [2*W-1:0] acc;
    logic           load, ctr_en, ctr_clr, tc, exit_clr, run_last;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    assign mplier_nxt = mplier_mag >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign exit_clr = (mplier_nxt == '0);
`else
    assign exit_clr = 1'b0;
`endif
    assign run_last = tc || exit_clr;

    seq_mult_step_ctr #(.W(W), .CW(CW)) u_step_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .count (step),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = run_last ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        load    = 1'b0;
        ctr_en  = 1'b0;
        ctr_clr = 1'b0;
        case (state)
            IDLE: begin
                load    = start;
                ctr_clr = start;
            end
            RUN: begin
                busy    = 1'b1;
                ctr_en  = 1'b1;
                ctr_clr = exit_clr;
            end
            FIN:     busy = 1'b1;
            default: ;
        endcase
    end

    // Negating a zero accumulator yields zero, so no special case is needed for -0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_mag  <= '0;
            mplier_mag <= '0;
            neg        <= 1'b0;
            acc        <= '0;
            product    <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (load) begin
                mcand_mag  <= mag(multiplicand);
                mplier_mag <= mag(multiplier);
                neg        <= multiplicand[W-1] ^ multiplier[W-1];
                acc        <= '0;
            end else if (state == RUN) begin
                if (mplier_mag[0]) begin
                    acc <= acc + ({{W{1'b0}}, mcand_mag} << step);
                end
                mplier_mag <= mplier_nxt;
            end else if (state == FIN) begin
                product <= neg ? -acc : acc;
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_mult_core.sv
// Bench for seq_signed_mult_core: directed corner cases plus random operands against an integer model.
module tb_seq_signed_mult_core;

    localparam int W  = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    multiplicand = '0;
    logic [W-1:0]    multiplier = '0;
    logic            busy, done;
    logic [2*W-1:0]  product;
    logic [CW-1:0]   step;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod = '0;

    seq_signed_mult_core #(.W(W), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .step         (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_product(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return (2*W)'(p);
    endfunction

    // Edges from the accepting edge until done is visible.
    function automatic int ref_latency(input logic signed [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int m;
        int h;
        m = (b < 0) ? -int'(b) : int'(b);
        if (m == 0) return 2;
        h = 0;
        for (int i = 0; i < 2*W; i++) if ((m >> i) & 1) h = i;
        return h + 2;
`else
        return W + 1;
`endif
    endfunction

    task automatic start_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        exp_q.push_back(ref_product(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input int reissue_at,
                             input logic signed [W-1:0] ra, input logic signed [W-1:0] rb);
        int n;
        bit held;
        logic [2*W-1:0] e;
        n = 0;
        held = 1'b1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done && n < 4*W) begin
            if (product !== last_prod) held = 1'b0;
            if (n == 2 && exp_lat > 3) chk("step_mid_run", 32'(step), 32'd2);
            if (n == reissue_at) begin
                multiplicand = ra;
                multiplier   = rb;
                start        = 1'b1;
            end
            @(negedge clk);
            n++;
            start = 1'b0;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("product_held", 32'(held), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("product", 32'(product), 32'(e));
            last_prod = e;
        end else begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=done expected=no_done");
        end
        chk("step_at_done", 32'(step), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic finish_op();
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("product_stable", 32'(product), 32'(last_prod));
    endtask

    task automatic count_idle_dones(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic signed [W-1:0] da[8];
        logic signed [W-1:0] db[8];
        logic signed [W-1:0] ra, rb;

        da = '{8'sd5, -8'sd5, -8'sd128, -8'sd128, 8'sd0, 8'sd7, -8'sd1, 8'sd127};
        db = '{8'sd3, 8'sd3, -8'sd128, 8'sd127, -8'sd7, 8'sd0, -8'sd1, -8'sd128};

        // Reset held low for three cycles.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_product", 32'(product), 32'd0);

        for (int i = 0; i < 8; i++) begin
            start_op(da[i], db[i]);
            wait_done(ref_latency(db[i]), -1, '0, '0);
            finish_op();
        end

        // A second start while busy must be dropped.
        start_op(8'sd7, 8'sd7);
        wait_done(ref_latency(8'sd7), 3, 8'sd1, 8'sd1);
        finish_op();
        count_idle_dones("ignored_start_done", W + 4);

        // Start re-asserted in the done cycle is accepted.
        start_op(-8'sd7, 8'sd6);
        wait_done(ref_latency(8'sd6), -1, '0, '0);
        start_op(8'sd2, -8'sd3);
        wait_done(ref_latency(-8'sd3), -1, '0, '0);
        finish_op();

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            start_op(ra, rb);
            wait_done(ref_latency(rb), -1, '0, '0);
            finish_op();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of RUN aborts without done.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_prod = '0;
        start_op(8'sd9, 8'sd9);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_step", 32'(step), 32'd0);
        reset = 1'b1;
        count_idle_dones("abort_no_done", W + 4);
        chk("abort_product_after", 32'(product), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_signed_mult_core.md
Name: seq_signed_mult_core

Overview:
- Sequential shift-add signed multiplier datapath plus its controller, sitting directly downstream of the step counter.
- Accepts two signed W-bit operands on a start pulse and iterates one multiplier bit per clock, gated by an internal mod-W step counter.
- Produces a signed 2W-bit product with a one-cycle done pulse.
- Feeds the display/BCD stage of the multiplier top level.

Parameters:
- W, 8, operand width in bits (W >= 2).
- CW, 4, step counter width; must satisfy 2^CW >= W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- start  in  1  request pulse; honoured only in IDLE
- multiplicand  in  W  signed two's-complement operand A
- multiplier  in  W  signed two's-complement operand B
- busy  out  1  high in RUN and FIN
- done  out  1  one-cycle pulse when product becomes valid
- product  out  2W  signed result A*B, held until the next accepted start
- step  out  CW  current iteration index, for the display stage

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, busy=0, done=0, product=0, step=0, all internal registers 0. A reset mid-operation aborts the multiply with no done pulse. Reset overrides start.
- States: IDLE, RUN, FIN.
- IDLE: start==1 at an edge causes:
  - mcand_mag <= |A| and mplier_mag <= |B|, both as W-bit unsigned.
  - neg <= A[W-1]^B[W-1].
  - acc <= 0 (2W-bit unsigned), step <= 0, state <= RUN.
  - done is cleared on this edge.
- Magnitude rule: |-2^(W-1)| = 2^(W-1) fits unsigned W bits. No saturation anywhere.
- RUN, each edge:
  - If mplier_mag[0]==1, acc <= acc + (mcand_mag << step).
  - mplier_mag <= mplier_mag >> 1.
  - Step counter increments.
  - On the edge where step==W-1, the counter wraps to 0 and state <= FIN.
  - RUN therefore lasts exactly W cycles.
- FIN, one edge:
  - product <= neg ? -acc : acc, in 2W-bit two's complement.
  - done <= 1, state <= IDLE.
- Latency: start sampled at edge 0, done and product visible after edge W+1.
- done is high for exactly one cycle; product is stable from then until the edge that accepts the next start.
- start while busy==1 is ignored, with no queuing.
- start asserted in the cycle done is high is accepted, since state is IDLE. The next multiply begins and product keeps its old value until that multiply's FIN.
- A zero operand still takes the full W cycles and yields product=0; neg is ignored for a zero result, so there is no -0.
- Range: the largest result, (-2^(W-1))^2 = 2^(2W-2), fits in 2W-bit signed.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN
- Defined:
  - In RUN, if the next mplier_mag (after shift) is 0, go to FIN on that edge. The step counter is cleared to 0.
  - Latency becomes (index of highest set bit of |B|) + 2 edges. For B==0, RUN lasts 1 cycle.
  - done/product semantics are unchanged.
- Undefined: fixed W-cycle RUN as above. The early-exit comparator is absent.

Decomposition:
- Package seq_mult_pkg holds:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, FIN=2'b10.
  - Default widths W and CW.
- Unreachable state 2'b11 decodes to IDLE.
- Sub-module seq_mult_step_ctr:
  - mod-W counter with enable, synchronous clear and a terminal-count output (tc = step==W-1 && en).
  - Uses the same clk/reset polarity as this block.
  - Instantiated once; step comes from it.

Test Plan:
- Reset held 0 for 3 cycles, then released -> busy=0, done=0, product=0, step=0.
- A=5, B=3, start pulse -> busy for 9 cycles, done pulse after edge 9, product=16'd15. With EARLY_EXIT_EN, done after edge 3.
- A=-5 (8'hFB), B=3 -> product=16'hFFF1 (-15). A=-128, B=-128 -> product=16'h4000 (16384). A=-128, B=127 -> product=16'hC080 (-16256).
- Start during RUN with A=7, B=7, then start re-pulsed at cycle 4 with A=1, B=1 -> second request ignored; product=49, single done pulse.
- Start reasserted in the done cycle with A=2, B=-3 -> accepted. Product holds the previous result until the new done, then 16'hFFFA (-6).
- Reset driven to 0 at RUN cycle 4 -> next cycle IDLE, no done, product unchanged from the pre-start value (0 after reset).
